// File: rtl/tone_sequencer.sv
// Melody controller: steps through a small note table, holding each note for
// DUR beats followed by a silent gap, and drives the speaker note-select path.
module tone_sequencer #(
  parameter int DEPTH       = 16,
  parameter int DUR_W       = 4,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DUR_W+7:0] wr_data,
  output logic [7:0]       note,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    idx
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);

  logic [DUR_W+7:0] mem [DEPTH];

  logic [1:0]       state, state_d;
  logic [BW-1:0]    beat_cnt, beat_cnt_d;
  logic [DUR_W-1:0] beats_left, beats_left_d;
  logic [GW-1:0]    gap_cnt, gap_cnt_d;
  logic [AW-1:0]    idx_d;
  logic [7:0]       note_d;
  logic             done_d;

  logic [DUR_W-1:0] ent_dur;
  logic [7:0]       ent_note;
  logic             wrap;

  assign {ent_dur, ent_note} = mem[idx];

  // Looping only restarts a non-empty table; entry 0 ending the table means
  // nothing is playable, so the sequence finishes instead of spinning in LOAD.
  assign wrap = loop && (idx != '0);

  // NOTE: the note table is deliberately left out of reset; it holds plain
  // data, so clearing it would only add reset fan-out to every storage bit.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state;
    idx_d        = idx;
    note_d       = note;
    done_d       = 1'b0;
    beat_cnt_d   = beat_cnt;
    beats_left_d = beats_left;
    gap_cnt_d    = gap_cnt;

    if (state != S_IDLE && stop) begin
      state_d      = S_IDLE;
      note_d       = '0;
      idx_d        = '0;
      beat_cnt_d   = '0;
      beats_left_d = '0;
      gap_cnt_d    = '0;
    end else begin
      case (state)
        S_IDLE: begin
          note_d = '0;
          if (start && !stop) begin
            idx_d   = '0;
            state_d = S_LOAD;
          end
        end

        S_LOAD: begin
          if (ent_dur == '0) begin
            if (wrap) begin
              idx_d = '0;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            note_d       = ent_note;
            beat_cnt_d   = '0;
            beats_left_d = ent_dur;
            state_d      = S_PLAY;
          end
        end

        S_PLAY: begin
          if (beat_cnt == BEAT_LAST) begin
            beat_cnt_d = '0;
            if (beats_left == DUR_W'(1)) begin
              note_d    = '0;
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end else begin
              beats_left_d = beats_left - 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt_d = '0;
            if (idx == IDX_LAST) begin
              if (wrap) begin
                idx_d   = '0;
                state_d = S_LOAD;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              idx_d   = idx + 1'b1;
              state_d = S_LOAD;
            end
          end else begin
            gap_cnt_d = gap_cnt + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      note       <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      beat_cnt   <= '0;
      beats_left <= '0;
      gap_cnt    <= '0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      note       <= note_d;
      done       <= done_d;
      busy       <= (state_d != S_IDLE);
      beat_cnt   <= beat_cnt_d;
      beats_left <= beats_left_d;
      gap_cnt    <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed vector table, hand-written
// corner sequences and randomized tables against a timeline reference model.
module tb_tone_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic [7:0]  note;
  logic        busy;
  logic        done;
  logic [1:0]  idx;

  int n_checks = 0;
  int n_fail   = 0;

  tone_sequencer #(
    .DEPTH(4), .DUR_W(4), .BEAT_CYCLES(4), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .note(note), .busy(busy), .done(done), .idx(idx)
  );

  always #5 clk = ~clk;

  // Model of the table contents and the expected per-edge output timeline.
  int m_dur [4];
  int m_note [4];

  typedef struct {
    bit          lp;
    logic [11:0] o;
  } samp_t;

  samp_t exp_q[$];
  bit    trunc;

  typedef struct packed {
    logic        start;
    logic        stop;
    logic        wr_en;
    logic [1:0]  wa;
    logic [11:0] wd;
    logic [7:0]  en;
    logic        eb;
    logic        ed;
    logic [1:0]  ei;
  } vec_t;

  vec_t vecs [24];

  function automatic logic [11:0] pk(int n, bit b, bit d, int i);
    return {8'(n), b, d, 2'(i)};
  endfunction

  function automatic void add(bit lp, logic [11:0] o);
    samp_t s;
    s.lp = lp;
    s.o  = o;
    exp_q.push_back(s);
  endfunction

  // Expected outputs after each clock edge, starting with the START edge.
  // wraps = how many end-of-table decisions see LOOP=1 (lp is the LOOP drive).
  function automatic void build(int wraps, int maxlen);
    int i = 0;
    int w = wraps;
    bit fin = 0;
    bit eot;
    exp_q.delete();
    trunc = 0;
    add(w > 0, pk(0, 1, 0, 0));
    while (!fin) begin
      if (exp_q.size() > maxlen) begin
        trunc = 1;
        break;
      end
      eot = 0;
      if (m_dur[i] == 0) begin
        eot = 1;
      end else begin
        repeat (m_dur[i] * 4) add(w > 0, pk(m_note[i], 1, 0, i));
        repeat (2) add(w > 0, pk(0, 1, 0, i));
        if (i == 3) eot = 1;
        else begin
          i++;
          add(w > 0, pk(0, 1, 0, i));
        end
      end
      if (eot) begin
        if (i != 0 && w > 0) begin
          i = 0;
          add(1, pk(0, 1, 0, 0));
          w--;
        end else begin
          add(w > 0, pk(0, 0, 1, i));
          add(0, pk(0, 0, 0, i));
          fin = 1;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [11:0] exp);
    check(name, {20'h0, note, busy, done, idx}, {20'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int d, input int n);
    wr_en   = 1'b1;
    wr_addr = 2'(a);
    wr_data = {4'(d), 8'(n)};
    tick();
    wr_en    = 1'b0;
    m_dur[a]  = d;
    m_note[a] = n;
  endtask

  task automatic run_seq(input string name);
    foreach (exp_q[j]) begin
      start = (j == 0);
      loop  = exp_q[j].lp;
      tick();
      check_out($sformatf("%s[%0d]", name, j), exp_q[j].o);
    end
    start = 1'b0;
    loop  = 1'b0;
    if (trunc) begin
      stop = 1'b1;
      tick();
      check_out({name, "_stop"}, pk(0, 0, 0, 0));
      stop = 1'b0;
    end
  endtask

  initial begin
    // Reset out of power-up.
    repeat (3) @(posedge clk);
    #1;
    check_out("reset_init", pk(0, 0, 0, 0));
    rst_n = 1'b1;
    tick();

    // Directed vectors: START+STOP, STOP in note/gap/LOAD, write while busy.
    write_entry(0, 1, 8'h11);
    write_entry(1, 1, 8'h22);
    write_entry(2, 0, 0);
    write_entry(3, 0, 0);
    vecs[0]  = '{1, 1, 0, 0, 12'h000, 8'h00, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 12'h000, 8'h00, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0};
    vecs[5]  = '{0, 0, 1, 1, 12'h304, 8'h11, 1, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0};
    vecs[10] = '{0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 12'h000, 8'h22, 1, 0, 1};
    vecs[13] = '{0, 1, 0, 0, 12'h000, 8'h00, 0, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0};
    vecs[15] = '{0, 1, 0, 0, 12'h000, 8'h00, 0, 0, 0};
    vecs[16] = '{1, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[18] = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[19] = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 12'h000, 8'h11, 1, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 12'h000, 8'h00, 1, 0, 0};
    vecs[22] = '{0, 1, 0, 0, 12'h000, 8'h00, 0, 0, 0};
    vecs[23] = '{0, 0, 0, 0, 12'h000, 8'h00, 0, 0, 0};
    for (int v = 0; v < 24; v++) begin
      start   = vecs[v].start;
      stop    = vecs[v].stop;
      wr_en   = vecs[v].wr_en;
      wr_addr = vecs[v].wa;
      wr_data = vecs[v].wd;
      tick();
      check_out($sformatf("vec[%0d]", v), {vecs[v].en, vecs[v].eb, vecs[v].ed, vecs[v].ei});
    end
    start = 1'b0;
    stop  = 1'b0;
    wr_en = 1'b0;

    // Reset held for 3 cycles mid-play; table must survive it.
    write_entry(0, 2, 8'h01);
    write_entry(1, 1, 8'h80);
    write_entry(2, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("reset_play[%0d]", k), pk(0, 0, 0, 0));
    end
    rst_n = 1'b1;
    tick();

    build(0, 1000);
    run_seq("basic");
    build(1000, 60);
    run_seq("loop");
    build(1, 1000);
    run_seq("loop_drop");

    // Full table with no terminator wraps after entry 3.
    write_entry(0, 1, 8'h0A);
    write_entry(1, 2, 8'h0B);
    write_entry(2, 1, 8'h0C);
    write_entry(3, 1, 8'h0D);
    build(0, 1000);
    run_seq("full");
    build(1, 1000);
    run_seq("full_loop");

    // Empty table: LOOP=1 still finishes, and START held high re-runs it.
    write_entry(0, 0, 8'h55);
    build(5, 1000);
    run_seq("empty_loop");
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_out($sformatf("restart_load[%0d]", k), pk(0, 1, 0, 0));
      tick();
      check_out($sformatf("restart_done[%0d]", k), pk(0, 0, 1, 0));
    end
    start = 1'b0;
    tick();
    check_out("restart_idle", pk(0, 0, 0, 0));

    // Randomized tables and loop counts.
    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 4; a++) begin
        write_entry(a, $urandom_range(0, 3), $urandom_range(1, 255));
      end
      build($urandom_range(0, 2), 250);
      run_seq($sformatf("rand%0d", r));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
